// File: rtl/dac_interface_if.sv
// Sample stream into the DAC interface: valid/ready handshake carrying one DAC sample.
interface dac_interface_if #(
    parameter int unsigned DATA_W = 12
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dac_interface.sv
// Parallel DAC driver: buffers stream samples in a small FIFO and presents one
// sample per generated dac_clk period, flagging underruns when the FIFO runs dry.
module dac_interface #(
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned HALF_DIV   = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SIGNED_IN  = 1,
    parameter int unsigned STRETCH    = 1023
) (
    input  logic                          clk_in,
    input  logic                          rst,
    dac_interface_if.slave                s,
    input  logic                          clear_ur,
    output logic                          dac_clk,
    output logic [DATA_W-1:0]             data_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          underrun_led
);
    localparam int unsigned CNT_MAX = 2 * HALF_DIV - 1;
    localparam int unsigned CNT_W   = $clog2(2 * HALF_DIV);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned ST_W    = $clog2(STRETCH + 1);
    localparam logic [DATA_W-1:0] MID       = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] CONV_MASK = (SIGNED_IN != 0) ? MID : '0;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dac_clk_q, dac_clk_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              ur_q, ur_d;
    logic [ST_W-1:0]   stretch_q, stretch_d;
    logic              led_q, led_d;

    logic tick;
    logic empty;
    logic push;
    logic pop;
    logic s_ready_w;

    assign s_ready_w = (level_q != LVL_W'(FIFO_DEPTH));

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        data_d    = data_q;
        ur_d      = ur_q;
        stretch_d = stretch_q;

        tick      = (cnt_q == CNT_W'(CNT_MAX));
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        // dac_clk is derived from the next count so it stays aligned with cnt_q
        dac_clk_d = (cnt_d >= CNT_W'(HALF_DIV));

        empty = (level_q == '0);
        push  = s.s_valid && s_ready_w;
        pop   = tick && !empty;

        if (push) begin
            mem_d[wr_ptr_q] = s.s_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            data_d   = mem_q[rd_ptr_q] ^ CONV_MASK;
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // An empty tick wins over a coincident clear
        if (tick && empty) begin
            ur_d      = 1'b1;
            stretch_d = ST_W'(STRETCH);
        end else begin
            if (clear_ur) begin
                ur_d = 1'b0;
            end
            if (stretch_q != '0) begin
                stretch_d = stretch_q - ST_W'(1);
            end
        end

        led_d = (stretch_d != '0);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q     <= '0;
            dac_clk_q <= 1'b0;
            data_q    <= MID;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ur_q      <= 1'b0;
            stretch_q <= '0;
            led_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dac_clk_q <= dac_clk_d;
            data_q    <= data_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ur_q      <= ur_d;
            stretch_q <= stretch_d;
            led_q     <= led_d;
        end
    end

    assign s.s_ready    = s_ready_w;
    assign dac_clk      = dac_clk_q;
    assign data_out     = data_q;
    assign fifo_level   = level_q;
    assign underrun     = ur_q;
    assign underrun_led = led_q;
endmodule

// File: tb/tb_dac_interface.sv
// Randomized bench for dac_interface: a queue-based reference model predicts every output each cycle.
module tb_dac_interface;
    localparam int unsigned STRETCH = 1023;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_ur;
    logic        dac_clk;
    logic [11:0] data_out;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic        underrun_led;

    int checks = 0;
    int errors = 0;

    dac_interface_if #(.DATA_W(12)) sif ();

    dac_interface #(
        .DATA_W(12), .HALF_DIV(4), .FIFO_DEPTH(4), .SIGNED_IN(1), .STRETCH(STRETCH)
    ) dut (
        .clk_in(clk), .rst(rst), .s(sif), .clear_ur(clear_ur), .dac_clk(dac_clk),
        .data_out(data_out), .fifo_level(fifo_level), .underrun(underrun),
        .underrun_led(underrun_led)
    );

    always #5 clk = ~clk;

    // Reference model: t = clk_in edges since reset; a DAC period ends when t%8 == 7
    int          t = 0;
    logic [11:0] mq [$];
    logic [11:0] m_data;
    logic        m_ur;
    int          m_led;
    logic        m_tick;
    logic        m_acc;
    logic [18:0] m_vec;
    logic [18:0] obs_vec;

    assign obs_vec = {sif.s_ready, dac_clk, fifo_level, underrun, underrun_led, data_out};

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            mq.delete();
            m_data = 12'h800;
            m_ur = 1'b0;
            m_led = 0;
        end else begin
            m_tick = ((t % 8) == 7);
            m_acc = sif.s_valid && (mq.size() != 4);
            if (m_tick && mq.size() == 0) begin
                m_ur = 1'b1;
                m_led = STRETCH;
            end else begin
                if (m_led > 0) m_led = m_led - 1;
                if (clear_ur) m_ur = 1'b0;
                if (m_tick) m_data = 12'((int'(mq.pop_front()) + 2048) % 4096);
            end
            if (m_acc) mq.push_back(sif.s_data);
            t = t + 1;
        end
        m_vec = {(mq.size() != 4), ((t % 8) >= 4), 3'(mq.size()), m_ur, (m_led != 0), m_data};
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        sif.s_valid = 1'b0;
        sif.s_data = '0;
        clear_ur = 1'b0;
        rst = 1'b1;
        repeat (3) step();
        checks++; if (data_out !== 12'h800) begin errors++; $display("FAIL reset_data got %h exp 800", data_out); end
        checks++; if (dac_clk !== 1'b0) begin errors++; $display("FAIL reset_dac_clk got %b exp 0", dac_clk); end
        checks++; if (sif.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", sif.s_ready); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", underrun); end
        checks++; if (underrun_led !== 1'b0) begin errors++; $display("FAIL reset_led got %b exp 0", underrun_led); end
        rst = 1'b0;
    endtask

    task automatic test_conversion();
        logic [11:0] ins [4];
        logic [11:0] exp_out [4];
        logic [11:0] held;
        logic        prev;
        int          k;
        ins = '{12'h000, 12'h7FF, 12'h800, 12'hFFF};
        exp_out = '{12'h800, 12'hFFF, 12'h000, 12'h7FF};
        k = 0;
        held = '0;
        for (int i = 0; i < 4; i++) begin
            sif.s_valid = 1'b1;
            sif.s_data = ins[i];
            step();
            checks++; if (obs_vec !== m_vec) begin errors++; $display("FAIL conv_push i=%0d got %h exp %h", i, obs_vec, m_vec); end
        end
        sif.s_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            prev = dac_clk;
            step();
            checks++; if (obs_vec !== m_vec) begin errors++; $display("FAIL conv_model c=%0d got %h exp %h", c, obs_vec, m_vec); end
            if (prev && !dac_clk && k < 4) begin
                checks++; if (data_out !== exp_out[k]) begin errors++; $display("FAIL conv_value k=%0d got %h exp %h", k, data_out, exp_out[k]); end
                held = data_out;
                k++;
            end else if (!prev && dac_clk && k > 0 && k <= 4) begin
                checks++; if (data_out !== held) begin errors++; $display("FAIL conv_stable k=%0d got %h exp %h", k, data_out, held); end
            end
        end
        checks++; if (k != 4) begin errors++; $display("FAIL conv_count got %0d exp 4", k); end
    endtask

    task automatic test_backpressure();
        int waited;
        waited = 0;
        while ((t % 8) != 0 && waited < 16) begin step(); waited++; end
        sif.s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sif.s_data = 12'($urandom);
            step();
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level got %0d exp 4", fifo_level); end
        checks++; if (sif.s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", sif.s_ready); end
        for (int c = 0; c < 24; c++) begin
            sif.s_data = 12'($urandom);
            step();
            checks++; if (obs_vec !== m_vec) begin errors++; $display("FAIL bp_model c=%0d got %h exp %h", c, obs_vec, m_vec); end
        end
        sif.s_valid = 1'b0;
    endtask

    task automatic test_underrun();
        int n;
        logic [11:0] last;
        n = 0;
        while ((t % 8) == 7 && n < 4) begin step(); n++; end
        clear_ur = 1'b1;
        step();
        clear_ur = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear1 got %b exp 0", underrun); end
        n = 0;
        while (!(mq.size() == 0 && (t % 8) == 7) && n < 100) begin step(); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL ur_drain_timeout got %0d exp <100", n); end
        last = data_out;
        step();
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set got %b exp 1", underrun); end
        checks++; if (data_out !== last) begin errors++; $display("FAIL ur_hold got %h exp %h", data_out, last); end
        // keep the FIFO fed so only one underrun contributes to the LED pulse
        n = underrun_led ? 1 : 0;
        sif.s_valid = 1'b1;
        for (int c = 0; c < 1100 && underrun_led; c++) begin
            sif.s_data = 12'($urandom);
            step();
            if (underrun_led) n++;
        end
        checks++; if (n != 1023) begin errors++; $display("FAIL ur_led_len got %0d exp 1023", n); end
        checks++; if (obs_vec !== m_vec) begin errors++; $display("FAIL ur_model got %h exp %h", obs_vec, m_vec); end
        sif.s_valid = 1'b0;
        n = 0;
        while ((t % 8) == 7 && n < 4) begin step(); n++; end
        clear_ur = 1'b1;
        step();
        clear_ur = 1'b0;
        checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear2 got %b exp 0", underrun); end
        n = 0;
        while (!(mq.size() == 0 && (t % 8) == 7) && n < 100) begin step(); n++; end
        clear_ur = 1'b1;
        step();
        clear_ur = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_set_wins got %b exp 1", underrun); end
    endtask

    task automatic test_simultaneous();
        logic [11:0] d;
        int n;
        n = 0;
        while (!(mq.size() == 0 && (t % 8) == 7) && n < 100) begin step(); n++; end
        d = 12'($urandom);
        sif.s_valid = 1'b1;
        sif.s_data = d;
        step();
        sif.s_valid = 1'b0;
        checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL sim_ur got %b exp 1", underrun); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL sim_level got %0d exp 1", fifo_level); end
        repeat (8) step();
        checks++; if (data_out !== (d ^ 12'h800)) begin errors++; $display("FAIL sim_out got %h exp %h", data_out, d ^ 12'h800); end
        n = 0;
        while (mq.size() < 2 && n < 20) begin
            sif.s_valid = ((t % 8) != 7);
            sif.s_data = 12'($urandom);
            step();
            n++;
        end
        sif.s_valid = 1'b0;
        n = 0;
        while ((t % 8) != 7 && n < 10) begin step(); n++; end
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL sim_pre_level got %0d exp 2", fifo_level); end
        sif.s_valid = 1'b1;
        sif.s_data = 12'($urandom);
        step();
        sif.s_valid = 1'b0;
        checks++; if (fifo_level !== 3'd2) begin errors++; $display("FAIL sim_pushpop_level got %0d exp 2", fifo_level); end
        checks++; if (obs_vec !== m_vec) begin errors++; $display("FAIL sim_model got %h exp %h", obs_vec, m_vec); end
    endtask

    task automatic test_mid_reset();
        int n;
        n = 0;
        while (mq.size() != 3 && n < 40) begin
            sif.s_valid = (mq.size() < 3);
            sif.s_data = 12'($urandom);
            step();
            n++;
        end
        sif.s_valid = 1'b0;
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mr_pre_level got %0d exp 3", fifo_level); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mr_level got %0d exp 0", fifo_level); end
        checks++; if (data_out !== 12'h800) begin errors++; $display("FAIL mr_data got %h exp 800", data_out); end
        n = 0;
        while (!dac_clk && n < 20) begin step(); n++; end
        checks++; if (n != 4) begin errors++; $display("FAIL mr_first_rise got %0d exp 4", n); end
    endtask

    task automatic test_random();
        int rate;
        rate = 50;
        for (int c = 0; c < 3000; c++) begin
            if ((c % 200) == 0) rate = $urandom_range(0, 100);
            sif.s_valid = ($urandom_range(0, 99) < rate);
            sif.s_data = 12'($urandom);
            clear_ur = ($urandom_range(0, 39) == 0);
            step();
            checks++; if (obs_vec !== m_vec) begin errors++; $display("FAIL rnd c=%0d got %h exp %h", c, obs_vec, m_vec); end
        end
        sif.s_valid = 1'b0;
        clear_ur = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_conversion();
        test_backpressure();
        test_underrun();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
